pum_apb_regbank: RTL and testbench
==================================

PUM_APB_REGBANK -- requirements
Module: pum_apb_regbank

Interface
REQ-001 SHALL provide parameters, one per line:
  NUM_BANKS, 3, number of data banks (R1/R2/RA style).
  BANK_DEPTH, 32, 32-bit words per bank.
  ADDR_W, 9, APB byte-address width.
  WAIT_STATES, 0, extra ACCESS cycles before pready.
REQ-002 SHALL have ports, one per line:
  clk  in  1  sole clock; all logic on its rising edge.
  rst  in  1  synchronous, active-high reset.
  psel  in  1  APB select.
  penable  in  1  APB enable.
  pwrite  in  1  1 = write.
  paddr  in  ADDR_W  byte address; word index = paddr[ADDR_W-1:2].
  pwdata  in  32  write data.
  prdata  out  32  read data, valid while pready=1.
  pready  out  1  transfer complete.
  pslverr  out  1  transfer error, valid while pready=1.
  dim_a_ver  out  32  register word 0.
  dim_b_ver  out  32  register word 1.
  tpum_mode  out  3  register word 5, bits [2:0].
  start_pulse  out  1  one-cycle start strobe.
  core_busy  in  1  core running.
  core_done  in  1  one-cycle completion pulse.
  core_result  in  32  result, captured on core_done.
  core_bank_sel  in  $clog2(NUM_BANKS)  bank selected for the core read.
  core_word  in  $clog2(BANK_DEPTH)  word selected for the core read.
  core_rdata  out  32  combinational read of the selected bank word.

Function
REQ-003 SHALL implement an APB FSM with three states:
  IDLE -> SETUP on psel & !penable.
  SETUP -> ACCESS on the next cycle.
  ACCESS holds for WAIT_STATES cycles, then asserts pready for exactly one cycle and returns to IDLE.
REQ-004 SHALL keep pready=0 outside that completion cycle; psel/penable violations return the FSM to IDLE with no side effects.
REQ-005 SHALL commit writes, and drive prdata for reads, only in the pready cycle; read latency is 2+WAIT_STATES cycles after SETUP.
REQ-006 SHALL decode the register map as follows:
  Words 0-4, 7-10 and 13-15: read/write.
  Word 5: tpum_mode, bits [2:0] only, upper bits read 0.
  Word 6: start; writing bit0=1 pulses start_pulse for one cycle (the cycle after commit); reads 0.
  Word 11: result, read-only, loaded from core_result when core_done=1.
  Word 12: status; bit0 = core_busy (live), bit1 = done sticky, bits[31:16] = done counter.
  Bank b, word w: word index 16 + b*BANK_DEPTH + w.
REQ-007 SHALL set the done sticky bit on core_done, clear it when word 12 is written with bit1=1, and have set win when both occur in the same cycle.
REQ-008 SHALL increment the 16-bit done counter on each core_done, wrapping 0xFFFF -> 0x0000.
REQ-009 SHALL ignore writes to words 0, 1, 5 and 6 while core_busy=1.
REQ-010 SHALL return prdata=0 for reads of unmapped word indices and drop writes to them.
REQ-011 SHALL elaborate only when 16 + NUM_BANKS*BANK_DEPTH <= 2^(ADDR_W-2); otherwise $error.

Reset
REQ-012 SHALL, when rst=1 at a clock edge:
  Set the FSM to IDLE and drive pready=0, pslverr=0, prdata=0, start_pulse=0.
  Clear all registers, banks, the sticky bit and the counter to 0.
  Abandon any in-flight transfer without committing it.

Configuration
REQ-013 SHALL, with PUM_REGBANK_PSLVERR_EN defined, assert pslverr in the pready cycle when:
  the access is unmapped, or
  the access writes a read-only word (11), or
  the access is a REQ-009 blocked write.
REQ-014 SHALL, without PUM_REGBANK_PSLVERR_EN, tie pslverr to 0; blocked and illegal accesses remain silently dropped.

Structure
REQ-015 SHALL place the following in package pum_regbank_pkg:
  register word-index constants (DIM_A=0 ... STATUS=12, BANK_BASE=16);
  the APB FSM state enum;
  mode encodings (BNN_OP=3'b010).
REQ-016 SHALL implement the bank storage as sub-module pum_reg_bank, one instance per bank, with one write port and two read ports (APB and core).

Verification
REQ-017 SHALL cover these directed scenarios:
  Write word 0 = 10, word 1 = 10, word 5 = 2, then read each -> 10, 10, 2; pready appears 2+WAIT_STATES cycles after SETUP.
  Write word 6 = 1 with core_busy=0 -> start_pulse high for exactly one cycle; reading word 6 -> 0.
  core_busy=1, write word 0 = 5 -> word 0 unchanged; pslverr=1 only when PUM_REGBANK_PSLVERR_EN is defined.
  core_done with core_result=0xA1A1A1A1 -> word 11 reads 0xA1A1A1A1 and word 12 reads 0x00010002 (busy=0).
  Write 0xE0000000|i to every word of bank 2, read back -> matches; core_rdata at (bank 2, word 31) = 0xE000001F.
  Assert rst during ACCESS with WAIT_STATES=3 -> no pready, no commit, and all reads afterwards return 0.

Source files
------------

// File: rtl/pum_apb_regbank_pkg.sv
// Shared register-map constants, APB FSM state type and mode encodings
// for the PUM APB register bank.
package pum_regbank_pkg;

    localparam int DIM_A     = 0;
    localparam int DIM_B     = 1;
    localparam int MODE      = 5;
    localparam int START     = 6;
    localparam int RESULT    = 11;
    localparam int STATUS    = 12;
    localparam int BANK_BASE = 16;

    localparam logic [2:0] BNN_OP = 3'b010;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    // Plain storage words below the bank window; special words are decoded separately.
    function automatic logic is_rw_word(input logic [31:0] idx);
        return (idx < 32'(BANK_BASE)) && !(idx inside {MODE, START, RESULT, STATUS});
    endfunction

endpackage

// File: rtl/pum_apb_regbank_if.sv
// APB completer-side bus bundle used by the PUM register bank.
interface pum_apb_regbank_if #(
    parameter int ADDR_W = 9
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/pum_apb_regbank_bank.sv
// One data bank: single write port, independent APB and core read ports.
module pum_reg_bank #(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] apb_raddr_i,
    output logic [31:0]   apb_rdata_o,
    input  logic [AW-1:0] core_raddr_i,
    output logic [31:0]   core_rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign apb_rdata_o  = mem_q[apb_raddr_i];
    assign core_rdata_o = mem_q[core_raddr_i];
endmodule

// File: rtl/pum_apb_regbank.sv
// APB register bank for the PUM core: control words, result/status and data banks.
// Optional macro PUM_REGBANK_PSLVERR_EN reports unmapped, read-only and busy-blocked accesses.
module pum_apb_regbank
    import pum_regbank_pkg::*;
#(
    parameter  int NUM_BANKS   = 3,
    parameter  int BANK_DEPTH  = 32,
    parameter  int ADDR_W      = 9,
    parameter  int WAIT_STATES = 0,
    localparam int BSEL_W      = $clog2(NUM_BANKS),
    localparam int WORD_W      = $clog2(BANK_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    pum_apb_regbank_if.slave  apb,
    output logic [31:0]       dim_a_ver,
    output logic [31:0]       dim_b_ver,
    output logic [2:0]        tpum_mode,
    output logic              start_pulse,
    input  logic              core_busy,
    input  logic              core_done,
    input  logic [31:0]       core_result,
    input  logic [BSEL_W-1:0] core_bank_sel,
    input  logic [WORD_W-1:0] core_word,
    output logic [31:0]       core_rdata
);
    localparam int               CNT_W     = $clog2(WAIT_STATES + 2);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);
    localparam int               MAP_END   = BANK_BASE + NUM_BANKS * BANK_DEPTH;

    if (MAP_END > (1 << (ADDR_W - 2))) begin : g_map_check
        $error("pum_apb_regbank: register map does not fit in ADDR_W");
    end

    apb_state_e       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             xfer_done, wr_ok, mapped, locked, ro_hit, unused_addr_lsbs;
    logic [31:0]      widx, rd_word;
    logic [31:0]      regs_q [16];
    logic [2:0]       mode_q;
    logic             start_q, sticky_q;
    logic [31:0]      result_q;
    logic [15:0]      done_cnt_q;
    logic [NUM_BANKS-1:0] bank_hit;
    logic [31:0]      bank_apb_rd  [NUM_BANKS];
    logic [31:0]      bank_core_rd [NUM_BANKS];

    assign widx             = 32'(apb.paddr[ADDR_W-1:2]);
    assign unused_addr_lsbs = ^apb.paddr[1:0];
    assign mapped           = widx < 32'(MAP_END);
    assign locked           = core_busy && (widx inside {DIM_A, DIM_B, MODE, START});
    assign ro_hit           = widx == 32'(RESULT);
    assign wr_ok            = xfer_done && apb.pwrite && mapped && !ro_hit && !locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= APB_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Any psel/penable sequence other than setup-then-access drops back to IDLE.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            APB_IDLE: begin
                if (apb.psel && !apb.penable) state_d = APB_SETUP;
            end
            APB_SETUP: begin
                wait_d  = '0;
                state_d = (apb.psel && apb.penable) ? APB_ACCESS : APB_IDLE;
            end
            APB_ACCESS: begin
                if (!(apb.psel && apb.penable) || wait_q == WAIT_LAST) state_d = APB_IDLE;
                else wait_d = wait_q + 1'b1;
            end
            default: state_d = APB_IDLE;
        endcase
    end

    always_comb begin
        xfer_done  = (state_q == APB_ACCESS) && (wait_q == WAIT_LAST) && apb.psel && apb.penable;
        apb.pready = xfer_done;
        apb.prdata = (xfer_done && !apb.pwrite) ? rd_word : '0;
`ifdef PUM_REGBANK_PSLVERR_EN
        apb.pslverr = xfer_done && (!mapped || (apb.pwrite && (ro_hit || locked)));
`else
        apb.pslverr = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (wr_ok && is_rw_word(widx)) begin
            regs_q[widx[3:0]] <= apb.pwdata;
        end
    end

    // A done pulse takes priority over a software clear of the sticky bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= '0;
            start_q    <= 1'b0;
            result_q   <= '0;
            done_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            if (wr_ok && widx == 32'(MODE)) mode_q <= apb.pwdata[2:0];
            start_q <= wr_ok && (widx == 32'(START)) && apb.pwdata[0];
            if (core_done) begin
                result_q   <= core_result;
                done_cnt_q <= done_cnt_q + 16'd1;
                sticky_q   <= 1'b1;
            end else if (wr_ok && widx == 32'(STATUS) && apb.pwdata[1]) begin
                sticky_q   <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam int LO = BANK_BASE + b * BANK_DEPTH;
        logic [WORD_W-1:0] boff;

        assign boff        = WORD_W'(widx - 32'(LO));
        assign bank_hit[b] = (widx >= 32'(LO)) && (widx < 32'(LO + BANK_DEPTH));

        pum_reg_bank #(.DEPTH(BANK_DEPTH)) u_bank (
            .clk          (clk),
            .rst          (rst),
            .we_i         (wr_ok && bank_hit[b]),
            .waddr_i      (boff),
            .wdata_i      (apb.pwdata),
            .apb_raddr_i  (boff),
            .apb_rdata_o  (bank_apb_rd[b]),
            .core_raddr_i (core_word),
            .core_rdata_o (bank_core_rd[b])
        );
    end

    always_comb begin
        rd_word = '0;
        if (is_rw_word(widx))            rd_word = regs_q[widx[3:0]];
        else if (widx == 32'(MODE))      rd_word = {29'd0, mode_q};
        else if (widx == 32'(RESULT))    rd_word = result_q;
        else if (widx == 32'(STATUS))    rd_word = {done_cnt_q, 14'd0, sticky_q, core_busy};
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_hit[b]) rd_word = bank_apb_rd[b];
        end
    end

    always_comb begin
        core_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (32'(core_bank_sel) == 32'(b)) core_rdata = bank_core_rd[b];
        end
    end

    assign dim_a_ver   = regs_q[DIM_A];
    assign dim_b_ver   = regs_q[DIM_B];
    assign tpum_mode   = mode_q;
    assign start_pulse = start_q;
endmodule

// File: tb/tb_pum_apb_regbank.sv
// Directed self-checking bench for pum_apb_regbank (WAIT_STATES=3); honours
// PUM_REGBANK_PSLVERR_EN when choosing the expected pslverr value.
module tb_pum_apb_regbank;
    import pum_regbank_pkg::*;

    localparam int WS  = 3;
    localparam int AW  = 9;
    localparam int LAT = 2 + WS;
`ifdef PUM_REGBANK_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        core_busy, core_done;
    logic [31:0] core_result, dim_a_ver, dim_b_ver, core_rdata;
    logic [1:0]  core_bank_sel;
    logic [4:0]  core_word;
    logic [2:0]  tpum_mode;
    logic        start_pulse;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic        err;
    int          lat;

    pum_apb_regbank_if #(.ADDR_W(AW)) bus ();

    pum_apb_regbank #(
        .NUM_BANKS(3), .BANK_DEPTH(32), .ADDR_W(AW), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst(rst), .apb(bus),
        .dim_a_ver(dim_a_ver), .dim_b_ver(dim_b_ver), .tpum_mode(tpum_mode),
        .start_pulse(start_pulse), .core_busy(core_busy), .core_done(core_done),
        .core_result(core_result), .core_bank_sel(core_bank_sel),
        .core_word(core_word), .core_rdata(core_rdata)
    );

    always #5 clk = ~clk;

    // One full APB transfer; returns at 1ns after the commit edge.
    task automatic applyStimulus(input logic wr, input int word, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic perr, output int cycles);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = AW'(word * 4); bus.pwdata = wdata;
        @(negedge clk);
        bus.penable = 1'b1;
        cycles = 1;
        while (bus.pready !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (bus.pready !== 1'b1) begin
            checks++; errors++;
            $display("[TB] FAIL apb_timeout word=%0d got pready=%b exp=1", word, bus.pready);
        end
        rdata = bus.prdata;
        perr  = bus.pslverr;
        @(posedge clk);
        #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.pready !== 1'b0) begin errors++; $display("[TB] FAIL reset_pready got=%b exp=0", bus.pready); end
        checks++; if (bus.prdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_prdata got=%h exp=0", bus.prdata); end
        checks++; if (bus.pslverr !== 1'b0) begin errors++; $display("[TB] FAIL reset_pslverr got=%b exp=0", bus.pslverr); end
        checks++; if (start_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got=%b exp=0", start_pulse); end
        checks++; if (dim_a_ver !== 32'd0) begin errors++; $display("[TB] FAIL reset_dim_a got=%h exp=0", dim_a_ver); end
        checks++; if (tpum_mode !== 3'd0) begin errors++; $display("[TB] FAIL reset_mode got=%h exp=0", tpum_mode); end
    endtask

    task automatic test_basic_rw();
        int          words [5] = '{0, 1, 5, 3, 13};
        logic [31:0] wvals [5] = '{32'd10, 32'd10, 32'd2, 32'hDEADBEEF, 32'h1357_9BDF};
        logic [31:0] evals [5] = '{32'd10, 32'd10, 32'd2, 32'hDEADBEEF, 32'h1357_9BDF};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, words[i], wvals[i], rd, err, lat);
            checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL wr_latency w%0d got=%0d exp=%0d", words[i], lat, LAT); end
        end
        checks++; if (dim_a_ver !== 32'd10) begin errors++; $display("[TB] FAIL dim_a_ver got=%h exp=a", dim_a_ver); end
        checks++; if (dim_b_ver !== 32'd10) begin errors++; $display("[TB] FAIL dim_b_ver got=%h exp=a", dim_b_ver); end
        checks++; if (tpum_mode !== BNN_OP) begin errors++; $display("[TB] FAIL tpum_mode got=%h exp=2", tpum_mode); end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, words[i], 32'd0, rd, err, lat);
            checks++; if (rd !== evals[i]) begin errors++; $display("[TB] FAIL rd_w%0d got=%h exp=%h", words[i], rd, evals[i]); end
            checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL rd_latency w%0d got=%0d exp=%0d", words[i], lat, LAT); end
        end
        applyStimulus(1'b1, 5, 32'hFFFF_FFFA, rd, err, lat);
        applyStimulus(1'b0, 5, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'd2) begin errors++; $display("[TB] FAIL mode_mask got=%h exp=2", rd); end
    endtask

    task automatic test_start();
        applyStimulus(1'b1, 6, 32'd1, rd, err, lat);
        checks++; if (start_pulse !== 1'b1) begin errors++; $display("[TB] FAIL start_hi got=%b exp=1", start_pulse); end
        @(posedge clk); #1;
        checks++; if (start_pulse !== 1'b0) begin errors++; $display("[TB] FAIL start_lo got=%b exp=0", start_pulse); end
        applyStimulus(1'b0, 6, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL start_read got=%h exp=0", rd); end
        applyStimulus(1'b1, 6, 32'd2, rd, err, lat);
        checks++; if (start_pulse !== 1'b0) begin errors++; $display("[TB] FAIL start_bit1 got=%b exp=0", start_pulse); end
    endtask

    task automatic test_busy_block();
        core_busy = 1'b1;
        applyStimulus(1'b1, 0, 32'd5, rd, err, lat);
        checks++; if (err !== ERR_EN) begin errors++; $display("[TB] FAIL busy_err got=%b exp=%b", err, ERR_EN); end
        applyStimulus(1'b0, 0, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'd10) begin errors++; $display("[TB] FAIL busy_w0 got=%h exp=a", rd); end
        applyStimulus(1'b1, 6, 32'd1, rd, err, lat);
        checks++; if (start_pulse !== 1'b0) begin errors++; $display("[TB] FAIL busy_start got=%b exp=0", start_pulse); end
        applyStimulus(1'b1, 2, 32'h22, rd, err, lat);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL busy_w2_err got=%b exp=0", err); end
        applyStimulus(1'b0, 2, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'h22) begin errors++; $display("[TB] FAIL busy_w2 got=%h exp=22", rd); end
        core_busy = 1'b0;
    endtask

    task automatic test_done_status();
        @(negedge clk); core_result = 32'hA1A1_A1A1; core_done = 1'b1;
        @(negedge clk); core_done = 1'b0; core_result = 32'h0;
        applyStimulus(1'b0, 11, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'hA1A1_A1A1) begin errors++; $display("[TB] FAIL result got=%h exp=a1a1a1a1", rd); end
        applyStimulus(1'b0, 12, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'h0001_0002) begin errors++; $display("[TB] FAIL status got=%h exp=00010002", rd); end
        applyStimulus(1'b1, 11, 32'd0, rd, err, lat);
        checks++; if (err !== ERR_EN) begin errors++; $display("[TB] FAIL ro_err got=%b exp=%b", err, ERR_EN); end
        applyStimulus(1'b0, 11, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'hA1A1_A1A1) begin errors++; $display("[TB] FAIL ro_keep got=%h exp=a1a1a1a1", rd); end
        applyStimulus(1'b1, 12, 32'd2, rd, err, lat);
        core_busy = 1'b1;
        applyStimulus(1'b0, 12, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'h0001_0001) begin errors++; $display("[TB] FAIL status_clr got=%h exp=00010001", rd); end
        core_busy = 1'b0;
    endtask

    task automatic test_banks();
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 80 + i, 32'hE000_0000 | i, rd, err, lat);
        applyStimulus(1'b1, 48, 32'h11, rd, err, lat);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 80 + i, 32'd0, rd, err, lat);
            checks++; if (rd !== (32'hE000_0000 | i)) begin errors++; $display("[TB] FAIL bank2_w%0d got=%h exp=%h", i, rd, 32'hE000_0000 | i); end
        end
        applyStimulus(1'b0, 48, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'h11) begin errors++; $display("[TB] FAIL bank1_w0 got=%h exp=11", rd); end
        core_bank_sel = 2'd2; core_word = 5'd31; #1;
        checks++; if (core_rdata !== 32'hE000_001F) begin errors++; $display("[TB] FAIL core_b2w31 got=%h exp=e000001f", core_rdata); end
        core_bank_sel = 2'd0; #1;
        checks++; if (core_rdata !== 32'd0) begin errors++; $display("[TB] FAIL core_b0w31 got=%h exp=0", core_rdata); end
        applyStimulus(1'b1, 112, 32'h5A, rd, err, lat);
        checks++; if (err !== ERR_EN) begin errors++; $display("[TB] FAIL unmap_wr_err got=%b exp=%b", err, ERR_EN); end
        applyStimulus(1'b0, 112, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL unmap_rd got=%h exp=0", rd); end
        checks++; if (err !== ERR_EN) begin errors++; $display("[TB] FAIL unmap_rd_err got=%b exp=%b", err, ERR_EN); end
    endtask

    task automatic test_reset_abort();
        int   words [8] = '{0, 1, 2, 5, 11, 12, 111, 48};
        logic saw_ready = 1'b0;
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = AW'(3 * 4); bus.pwdata = 32'h1234;
        @(negedge clk); bus.penable = 1'b1; saw_ready |= bus.pready;
        @(negedge clk); rst = 1'b1;         saw_ready |= bus.pready;
        @(negedge clk); rst = 1'b0;         saw_ready |= bus.pready;
        repeat (6) begin @(negedge clk); saw_ready |= bus.pready; end
        bus.psel = 1'b0; bus.penable = 1'b0;
        checks++; if (saw_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_pready got=%b exp=0", saw_ready); end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, words[i], 32'd0, rd, err, lat);
            checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL post_rst_w%0d got=%h exp=0", words[i], rd); end
        end
        applyStimulus(1'b0, 3, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL abort_commit got=%h exp=0", rd); end
        core_bank_sel = 2'd2; core_word = 5'd31; #1;
        checks++; if (core_rdata !== 32'd0) begin errors++; $display("[TB] FAIL post_rst_core got=%h exp=0", core_rdata); end
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
        core_busy = 1'b0; core_done = 1'b0; core_result = '0;
        core_bank_sel = '0; core_word = '0;
        test_reset();
        test_basic_rw();
        test_start();
        test_busy_block();
        test_done_status();
        test_banks();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
